// File: rtl/dram_axi_bridge_pkg.sv
// Shared types and constants for the DRAM AXI4-Lite bridge.
// The state encoding, the DRAM window placement and the OKAY response code
// are kept here so the bridge and anything that talks to it agree on them.
package dram_axi_bridge_pkg;

    // Bridge FSM states. Values are fixed so the 3-bit state register stays
    // stable for anything that decodes it directly.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5,
        DONE = 3'd6
    } bridge_state_t;

    // Byte address of entry 0 and the byte distance between entries.
    localparam logic [16:0] DRAM_BASE   = 17'h10000;
    localparam int          DRAM_STRIDE = 8;

    // One DRAM entry is one 64-bit word.
    typedef logic [63:0] dram_word_t;

    // AXI response code for a successful access.
    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/dram_axi_bridge_if.sv
// AXI4-Lite channel bundle (INF) between the bridge and the pseudo DRAM.
// The bridge modport is the AXI master side, the dram modport the slave side.
interface dram_axi_bridge_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
);

    // Read address channel
    logic              AR_VALID;
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_READY;

    // Read data channel
    logic              R_VALID;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_READY;

    // Write address channel
    logic              AW_VALID;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              AW_READY;

    // Write data channel
    logic              W_VALID;
    logic [DATA_W-1:0] W_DATA;
    logic              W_READY;

    // Write response channel
    logic              B_VALID;
    logic [1:0]        B_RESP;
    logic              B_READY;

    // Master side: the bridge drives VALIDs, addresses, write data and
    // the READYs of the return channels.
    modport bridge (
        output AR_VALID, AR_ADDR,
        input  AR_READY,
        input  R_VALID, R_DATA, R_RESP,
        output R_READY,
        output AW_VALID, AW_ADDR,
        input  AW_READY,
        output W_VALID, W_DATA,
        input  W_READY,
        input  B_VALID, B_RESP,
        output B_READY
    );

    // Slave side: the DRAM model answers every channel.
    modport dram (
        input  AR_VALID, AR_ADDR,
        output AR_READY,
        output R_VALID, R_DATA, R_RESP,
        input  R_READY,
        input  AW_VALID, AW_ADDR,
        output AW_READY,
        input  W_VALID, W_DATA,
        output W_READY,
        output B_VALID, B_RESP,
        input  B_READY
    );

endinterface

// File: rtl/dram_axi_bridge.sv
// AXI4-Lite master that turns one OS-controller DRAM command (entry index,
// read or write) into the AR/R or AW/W/B sequence on INF and reports the
// result with a one-cycle completion pulse. Only one transaction is ever
// in flight; every output comes straight from a flop.
module dram_axi_bridge
    import dram_axi_bridge_pkg::*;
#(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 64,
    parameter int                IDX_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DRAM_BASE),
    parameter int                STRIDE    = DRAM_STRIDE
) (
    input  logic              clk,
    input  logic              rst,

    // Command side (OS controller)
    input  logic              C_in_valid,
    input  logic              C_r_wb,
    input  logic [IDX_W-1:0]  C_addr,
    input  logic [DATA_W-1:0] C_data_w,
    output logic              C_out_valid,
    output logic [DATA_W-1:0] C_data_r,
    output logic              C_err,

    // AXI4-Lite master port towards the DRAM model
    dram_axi_bridge_if.bridge inf
);

    // Local copies of the shared state encoding for the state register.
    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_AR   = AR;
    localparam logic [2:0] ST_R    = R;
    localparam logic [2:0] ST_AW   = AW;
    localparam logic [2:0] ST_W    = W;
    localparam logic [2:0] ST_B    = B;
    localparam logic [2:0] ST_DONE = DONE;

    // FSM state
    logic [2:0]        state_q,    state_d;

    // Channel handshake outputs
    logic              arValid_q,  arValid_d;
    logic              rReady_q,   rReady_d;
    logic              awValid_q,  awValid_d;
    logic              wValid_q,   wValid_d;
    logic              bReady_q,   bReady_d;

    // Datapath registers
    logic [ADDR_W-1:0] arAddr_q,   arAddr_d;
    logic [ADDR_W-1:0] awAddr_q,   awAddr_d;
    logic [DATA_W-1:0] wData_q,    wData_d;
    logic [DATA_W-1:0] readWord_q, readWord_d;
    logic              isRead_q,   isRead_d;
    logic              err_q,      err_d;

    // Command-side outputs
    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] dataR_q,    dataR_d;

    // Byte address of the requested entry; with an 8-bit index the largest
    // offset is 0x7F8, so it always fits in the address width.
    logic [ADDR_W-1:0] entryAddr;
    assign entryAddr = BASE_ADDR + ADDR_W'(C_addr) * ADDR_W'(STRIDE);

    // Next-state and next-output logic: each state only waits for its own
    // handshake, and the following channel's VALID/READY is raised by the
    // same transition so nothing depends combinationally on a same-cycle input.
    always_comb begin
        state_d    = state_q;
        arValid_d  = arValid_q;
        rReady_d   = rReady_q;
        awValid_d  = awValid_q;
        wValid_d   = wValid_q;
        bReady_d   = bReady_q;
        arAddr_d   = arAddr_q;
        awAddr_d   = awAddr_q;
        wData_d    = wData_q;
        readWord_d = readWord_q;
        isRead_d   = isRead_q;
        err_d      = err_q;
        outValid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (C_in_valid) begin
                    isRead_d = C_r_wb;
                    err_d    = 1'b0;
                    if (C_r_wb) begin
                        arAddr_d  = entryAddr;
                        arValid_d = 1'b1;
                        state_d   = ST_AR;
                    end else begin
                        awAddr_d  = entryAddr;
                        wData_d   = C_data_w;
                        awValid_d = 1'b1;
                        state_d   = ST_AW;
                    end
                end
            end
            ST_AR: begin
                if (inf.AR_READY) begin
                    arValid_d = 1'b0;
                    rReady_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (inf.R_VALID) begin
                    rReady_d   = 1'b0;
                    readWord_d = inf.R_DATA;
                    err_d      = (inf.R_RESP != RESP_OKAY);
                    outValid_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_AW: begin
                if (inf.AW_READY) begin
                    awValid_d = 1'b0;
                    wValid_d  = 1'b1;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (inf.W_READY) begin
                    wValid_d = 1'b0;
                    bReady_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: begin
                if (inf.B_VALID) begin
                    bReady_d   = 1'b0;
                    err_d      = (inf.B_RESP != RESP_OKAY);
                    outValid_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                arValid_d = 1'b0;
                rReady_d  = 1'b0;
                awValid_d = 1'b0;
                wValid_d  = 1'b0;
                bReady_d  = 1'b0;
            end
        endcase

        // The read word is shown except during a write's completion pulse,
        // where the data bus is forced to zero; afterwards the last read word
        // reappears until another read replaces it.
        dataR_d = (state_d == ST_DONE && !isRead_d) ? '0 : readWord_d;
    end

    // State and output registers; reset drops every VALID/READY at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            arValid_q  <= 1'b0;
            rReady_q   <= 1'b0;
            awValid_q  <= 1'b0;
            wValid_q   <= 1'b0;
            bReady_q   <= 1'b0;
            arAddr_q   <= '0;
            awAddr_q   <= '0;
            wData_q    <= '0;
            readWord_q <= '0;
            isRead_q   <= 1'b0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
            dataR_q    <= '0;
        end else begin
            state_q    <= state_d;
            arValid_q  <= arValid_d;
            rReady_q   <= rReady_d;
            awValid_q  <= awValid_d;
            wValid_q   <= wValid_d;
            bReady_q   <= bReady_d;
            arAddr_q   <= arAddr_d;
            awAddr_q   <= awAddr_d;
            wData_q    <= wData_d;
            readWord_q <= readWord_d;
            isRead_q   <= isRead_d;
            err_q      <= err_d;
            outValid_q <= outValid_d;
            dataR_q    <= dataR_d;
        end
    end

    assign inf.AR_VALID = arValid_q;
    assign inf.AR_ADDR  = arAddr_q;
    assign inf.R_READY  = rReady_q;
    assign inf.AW_VALID = awValid_q;
    assign inf.AW_ADDR  = awAddr_q;
    assign inf.W_VALID  = wValid_q;
    assign inf.W_DATA   = wData_q;
    assign inf.B_READY  = bReady_q;

    assign C_out_valid  = outValid_q;
    assign C_data_r     = dataR_q;
    assign C_err        = err_q;

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Directed testbench for dram_axi_bridge with a small behavioural DRAM slave.
// The slave's per-channel wait states and responses are set by each test.
module tb_dram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        C_in_valid;
    logic        C_r_wb;
    logic [7:0]  C_addr;
    logic [63:0] C_data_w;
    logic        C_out_valid;
    logic [63:0] C_data_r;
    logic        C_err;

    dram_axi_bridge_if #(.ADDR_W(17), .DATA_W(64)) inf ();

    dram_axi_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r),
        .C_err       (C_err),
        .inf         (inf)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Slave configuration, written by the stimulus only
    int         arDelay  = 0;
    int         rDelay   = 0;
    int         awDelay  = 0;
    int         wDelay   = 0;
    int         bDelay   = 0;
    logic [1:0] rResp    = 2'b00;
    logic [1:0] bResp    = 2'b00;
    logic       tiedHigh = 1'b0;

    // Slave model state
    logic [63:0] mem [0:255];
    logic        memInit = 1'b0;
    logic        rPend, bPend, awGot;
    int          arCnt, rCnt, awCnt, wCnt, bCnt;
    logic [7:0]  rIdx, awIdx;
    int          wEarly = 0;
    int          doneCount = 0;

    // Handshakes seen at the last rising edge
    logic        arHs = 1'b0, rHs = 1'b0, awHs = 1'b0, wHs = 1'b0, bHs = 1'b0;
    logic [16:0] arHsAddr, awHsAddr;
    logic [63:0] wHsData;

    function automatic logic [7:0] addrToIdx(input logic [16:0] a);
        logic [16:0] off;
        off = a - 17'h10000;
        return off[10:3];
    endfunction

    // Record which handshakes completed on this edge
    always @(posedge clk) begin
        arHs     <= inf.AR_VALID && inf.AR_READY;
        arHsAddr <= inf.AR_ADDR;
        rHs      <= inf.R_VALID && inf.R_READY;
        awHs     <= inf.AW_VALID && inf.AW_READY;
        awHsAddr <= inf.AW_ADDR;
        wHs      <= inf.W_VALID && inf.W_READY;
        wHsData  <= inf.W_DATA;
        bHs      <= inf.B_VALID && inf.B_READY;
        if (C_out_valid) doneCount <= doneCount + 1;
    end

    // DRAM slave: reacts on the falling edge to the handshakes just recorded
    always @(negedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 256; i++)
                mem[i] = {32'hCAFE0000 + 32'(i), 32'h0BAD0000 + 32'(i)};
            memInit = 1'b1;
        end
        if (rst) begin
            inf.AR_READY = 1'b0; inf.R_VALID = 1'b0; inf.R_DATA = '0; inf.R_RESP = 2'b00;
            inf.AW_READY = 1'b0; inf.W_READY = 1'b0; inf.B_VALID = 1'b0; inf.B_RESP = 2'b00;
            rPend = 1'b0; bPend = 1'b0; awGot = 1'b0;
            arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
            rIdx = '0; awIdx = '0;
        end else begin
            if (rHs) begin inf.R_VALID = 1'b0; rPend = 1'b0; end
            if (arHs) begin rPend = 1'b1; rIdx = addrToIdx(arHsAddr); rCnt = rDelay; end
            if (rPend && !inf.R_VALID) begin
                if (rCnt == 0) begin
                    inf.R_VALID = 1'b1; inf.R_DATA = mem[rIdx]; inf.R_RESP = rResp;
                end else rCnt--;
            end
            if (tiedHigh) inf.AR_READY = 1'b1;
            else if (inf.AR_VALID) begin
                if (arCnt >= arDelay) inf.AR_READY = 1'b1;
                else begin inf.AR_READY = 1'b0; arCnt++; end
            end else begin inf.AR_READY = 1'b0; arCnt = 0; end

            if (wHs) begin mem[awIdx] = wHsData; awGot = 1'b0; bPend = 1'b1; bCnt = bDelay; end
            if (awHs) begin awGot = 1'b1; awIdx = addrToIdx(awHsAddr); end
            if (bHs) begin inf.B_VALID = 1'b0; bPend = 1'b0; end
            if (bPend && !inf.B_VALID) begin
                if (bCnt == 0) begin inf.B_VALID = 1'b1; inf.B_RESP = bResp; end
                else bCnt--;
            end
            if (inf.W_VALID && !awGot) wEarly++;
            if (tiedHigh) inf.AW_READY = 1'b1;
            else if (inf.AW_VALID) begin
                if (awCnt >= awDelay) inf.AW_READY = 1'b1;
                else begin inf.AW_READY = 1'b0; awCnt++; end
            end else begin inf.AW_READY = 1'b0; awCnt = 0; end
            if (tiedHigh) inf.W_READY = 1'b1;
            else if (inf.W_VALID) begin
                if (wCnt >= wDelay) inf.W_READY = 1'b1;
                else begin inf.W_READY = 1'b0; wCnt++; end
            end else begin inf.W_READY = 1'b0; wCnt = 0; end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Issue one command; returns on the falling edge after it was captured
    task automatic applyStimulus(input logic rw, input logic [7:0] idx, input logic [63:0] data);
        @(negedge clk);
        C_in_valid = 1'b1; C_r_wb = rw; C_addr = idx; C_data_w = data;
        @(negedge clk);
        C_in_valid = 1'b0;
    endtask

    // Wait (bounded) for the completion pulse and capture its payload
    task automatic waitDone(output logic [63:0] data, output logic err, output int lat);
        logic found;
        found = 1'b0; lat = 0; data = '0; err = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (C_out_valid) begin found = 1'b1; data = C_data_r; err = C_err; break; end
            @(negedge clk);
            lat++;
        end
        checkOutput("doneSeen", 64'(found), 64'd1);
    endtask

    // The pulse must be gone one cycle later
    task automatic checkPulseEnd();
        @(negedge clk);
        checkOutput("pulseWidth", 64'(C_out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: no finish, limit 100000 ns reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] data;
        logic        err;
        int          lat, arHigh, addrBad, doneBefore, waitB;

        rst = 1'b1; C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = '0; C_data_w = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstArValid", 64'(inf.AR_VALID), 64'd0);
        checkOutput("rstAwValid", 64'(inf.AW_VALID), 64'd0);
        checkOutput("rstWValid",  64'(inf.W_VALID),  64'd0);
        checkOutput("rstReadys",  64'({inf.R_READY, inf.B_READY}), 64'd0);
        checkOutput("rstOut",     64'({C_out_valid, C_err}), 64'd0);
        checkOutput("rstDataR",   C_data_r, 64'd0);
        #1 rst = 1'b0;

        // Reset in the middle of a stalled read
        arDelay = 100;
        applyStimulus(1'b1, 8'h00, 64'd0);
        checkOutput("midArValid", 64'(inf.AR_VALID), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstArValid", 64'(inf.AR_VALID), 64'd0);
        checkOutput("midRstOut", 64'({C_out_valid, inf.R_READY}), 64'd0);
        checkOutput("midRstArAddr", 64'(inf.AR_ADDR), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        arDelay = 0;
        applyStimulus(1'b1, 8'h00, 64'd0);
        waitDone(data, err, lat);
        checkOutput("postRstData", data, 64'hCAFE0000_0BAD0000);
        checkOutput("postRstErr", 64'(err), 64'd0);
        checkPulseEnd();

        // Read idx 0 with AR_READY held off 15 cycles
        arDelay = 15; rDelay = 2;
        doneBefore = doneCount;
        applyStimulus(1'b1, 8'h00, 64'd0);
        arHigh = 0; addrBad = 0;
        for (int i = 0; i < 100 && inf.AR_VALID; i++) begin
            arHigh++;
            if (inf.AR_ADDR !== 17'h10000) addrBad++;
            @(negedge clk);
        end
        checkOutput("stallArHigh", 64'(arHigh), 64'd16);
        checkOutput("stallArAddr", 64'(addrBad), 64'd0);
        waitDone(data, err, lat);
        checkOutput("stallData", data, 64'hCAFE0000_0BAD0000);
        checkOutput("stallErr", 64'(err), 64'd0);
        checkPulseEnd();
        checkOutput("stallPulses", 64'(doneCount - doneBefore), 64'd1);
        arDelay = 0; rDelay = 0;

        // Write idx FF, then read it back
        awDelay = 2; wDelay = 1; bDelay = 3;
        applyStimulus(1'b0, 8'hFF, 64'hDEADBEEF_01234567);
        checkOutput("wrAwValid", 64'(inf.AW_VALID), 64'd1);
        checkOutput("wrAwAddr", 64'(inf.AW_ADDR), 64'h107F8);
        checkOutput("wrWNotYet", 64'(inf.W_VALID), 64'd0);
        waitDone(data, err, lat);
        checkOutput("wrDataR", data, 64'd0);
        checkOutput("wrErr", 64'(err), 64'd0);
        checkPulseEnd();
        checkOutput("wrEarlyW", 64'(wEarly), 64'd0);
        checkOutput("wrMem", mem[255], 64'hDEADBEEF_01234567);
        awDelay = 0; wDelay = 0; bDelay = 0;
        applyStimulus(1'b1, 8'hFF, 64'd0);
        waitDone(data, err, lat);
        checkOutput("readBack", data, 64'hDEADBEEF_01234567);
        checkPulseEnd();

        // Zero-wait slave: READYs tied high
        tiedHigh = 1'b1;
        doneBefore = doneCount;
        applyStimulus(1'b1, 8'h05, 64'd0);
        waitDone(data, err, lat);
        checkOutput("zwReadLat", 64'(lat), 64'd2);
        checkOutput("zwReadData", data, 64'hCAFE0005_0BAD0005);
        checkPulseEnd();
        applyStimulus(1'b0, 8'h06, 64'h0F0E0D0C_0B0A0908);
        waitDone(data, err, lat);
        checkOutput("zwWriteLat", 64'(lat), 64'd3);
        checkPulseEnd();
        repeat (3) @(negedge clk);
        checkOutput("zwPulses", 64'(doneCount - doneBefore), 64'd2);
        checkOutput("zwMem", mem[6], 64'h0F0E0D0C_0B0A0908);
        tiedHigh = 1'b0;

        // Error responses
        rResp = 2'b10;
        applyStimulus(1'b1, 8'h10, 64'd0);
        waitDone(data, err, lat);
        checkOutput("errReadFlag", 64'(err), 64'd1);
        checkOutput("errReadData", data, 64'hCAFE0010_0BAD0010);
        checkPulseEnd();
        rResp = 2'b00;
        applyStimulus(1'b1, 8'h11, 64'd0);
        waitDone(data, err, lat);
        checkOutput("okReadFlag", 64'(err), 64'd0);
        checkOutput("okReadData", data, 64'hCAFE0011_0BAD0011);
        checkPulseEnd();
        bResp = 2'b11;
        applyStimulus(1'b0, 8'h40, 64'h5555AAAA_5555AAAA);
        waitDone(data, err, lat);
        checkOutput("errWriteFlag", 64'(err), 64'd1);
        checkPulseEnd();
        bResp = 2'b00;

        // Command while waiting for the write response
        bDelay = 10;
        doneBefore = doneCount;
        applyStimulus(1'b0, 8'h20, 64'h11223344_55667788);
        waitB = 0;
        while (!inf.B_READY && waitB < 50) begin @(negedge clk); waitB++; end
        checkOutput("busyReachB", 64'(inf.B_READY), 64'd1);
        applyStimulus(1'b1, 8'h30, 64'hFFFFFFFF_FFFFFFFF);
        checkOutput("busyStillB", 64'(inf.B_READY), 64'd1);
        checkOutput("busyAwAddr", 64'(inf.AW_ADDR), 64'h10100);
        checkOutput("busyWData", inf.W_DATA, 64'h11223344_55667788);
        checkOutput("busyNoAr", 64'(inf.AR_VALID), 64'd0);
        waitDone(data, err, lat);
        checkPulseEnd();
        repeat (6) @(negedge clk);
        checkOutput("busyPulses", 64'(doneCount - doneBefore), 64'd1);
        checkOutput("busyNoArLate", 64'(inf.AR_VALID), 64'd0);
        checkOutput("busyMem", mem[8'h20], 64'h11223344_55667788);
        bDelay = 0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dram_axi_bridge.md
Name: dram_axi_bridge

Overview:
- AXI4-Lite master bridging the OS controller's single-word DRAM requests to the pseudo DRAM slave over INF.
- Accepts one read or write command, converts an entry index to a byte address and runs the AR/R or AW/W/B channel sequence.
- Returns read data, or write completion, as a one-cycle pulse.
- One outstanding transaction; sits between the OS FSM and the DRAM model on the bridge side of INF.

Parameters:
ADDR_W, 17, AXI address width
DATA_W, 64, AXI data width (one DRAM word per entry)
IDX_W, 8, entry index width
BASE_ADDR, 17'h10000, byte address of entry 0
STRIDE, 8, bytes per entry

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
C_in_valid  in  1  command strobe (one cycle)
C_r_wb  in  1  1 = read, 0 = write
C_addr  in  IDX_W  entry index
C_data_w  in  DATA_W  write data
C_out_valid  out  1  completion pulse
C_data_r  out  DATA_W  read data (valid with C_out_valid on reads)
C_err  out  1  RESP != OKAY on completion (valid with C_out_valid)
AR_VALID  out  1  read address valid
AR_ADDR  out  ADDR_W  read address
AR_READY  in  1  read address ready
R_VALID  in  1  read data valid
R_DATA  in  DATA_W  read data
R_RESP  in  2  read response
R_READY  out  1  read data ready
AW_VALID  out  1  write address valid
AW_ADDR  out  ADDR_W  write address
AW_READY  in  1  write address ready
W_VALID  out  1  write data valid
W_DATA  out  DATA_W  write data
W_READY  in  1  write data ready
B_VALID  in  1  write response valid
B_RESP  in  2  write response
B_READY  out  1  write response ready

Behaviour:
- All outputs are registered and 0 at reset. Reset is asynchronous, active-high; asserting it mid-transaction forces IDLE and drops every VALID/READY immediately. The DRAM model is reset alongside.
- Address: BASE_ADDR + C_addr*STRIDE, computed once at command capture and held in a register. Width is ADDR_W, with no overflow possible for IDX_W = 8.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE: on C_in_valid, latch the address, C_data_w and C_r_wb. Go to AR (read) or AW (write). AR_VALID or AW_VALID rises on the next cycle.
- C_in_valid outside IDLE is ignored. The upstream block must not issue a command until C_out_valid.
- AR: AR_VALID = 1 with AR_ADDR stable until the cycle AR_READY = 1 (handshake). Then AR_VALID = 0 and go to R.
- R: R_READY = 1. On R_VALID & R_READY, capture R_DATA into C_data_r and set the error flag if R_RESP != 0. Then R_READY = 0 and go to DONE.
- AW: AW_VALID = 1 until AW_READY. Then go to W. AW and W are strictly sequential; W_VALID is never raised before the AW handshake.
- W: W_VALID = 1 with W_DATA stable until W_READY. Then go to B.
- B: B_READY = 1 until B_VALID. Capture B_RESP != 0 into the error flag. Then go to DONE.
- DONE: C_out_valid = 1 for exactly one cycle, with C_err. Return to IDLE.
  - Read: C_data_r holds the captured word until the next read completes.
  - Write: C_data_r is 0 during the pulse.
- A new command is accepted the cycle after DONE, so the minimum gap is one IDLE cycle.
- VALID never drops before its handshake; READY/VALID are never combinationally dependent on the same-cycle input.
- Latency with a zero-wait slave:
  - Read: C_in_valid at cycle t, AR_VALID at t+1, R handshake at t+2 or later, C_out_valid one cycle after the R handshake.
  - Write: same pattern through AW, W and B.
- A READY already high when VALID rises completes the handshake in that same cycle.
- A non-OKAY response does not abort or retry the transaction; it only sets C_err.

Decomposition:
- Shared package usertype:
  - enum bridge_state_t {IDLE, AR, R, AW, W, B, DONE}
  - constants DRAM_BASE = 17'h10000 and DRAM_STRIDE = 8
  - typedef dram_word_t = logic [63:0]
  - localparam RESP_OKAY = 2'b00
- No sub-module; a single FSM with a datapath register file is sufficient.
- Connects to the DRAM model through the INF bridge modport.

Test Plan:
- Reset mid-transaction: assert rst while AR_VALID = 1 -> AR_VALID = 0 asynchronously, state IDLE, C_out_valid = 0; the next read of idx 0 succeeds.
- Read with stalled slave: read idx 8'h00, AR_READY delayed 15 cycles -> AR_ADDR = 17'h10000 held stable; one C_out_valid pulse with C_data_r = dram[0x10000..0x10007]; C_err = 0.
- Write then read back: write idx 8'hFF, data 64'hDEADBEEF_01234567 -> AW_ADDR = 17'h107F8, W_VALID only after the AW handshake, one C_out_valid after B; a following read of idx FF returns the same data.
- Zero-wait slave: READYs tied high, R_VALID/B_VALID one cycle after the request -> read completes with C_out_valid at t+3; no double pulses.
- Error response: R_RESP = 2'b10 on a read of idx 8'h10 -> C_out_valid with C_err = 1 and data captured; the next OKAY transaction gives C_err = 0.
- Command while busy: second C_in_valid during state B -> ignored; exactly one completion and unchanged AW_ADDR/W_DATA.
